// File: rtl/countdown_timer.sv
// countdown_timer: seconds countdown feeding the two-digit display.
// Ports: clk, rst (async, active-high); start/load_val load a value,
//        hold freezes, cancel aborts; countdown_val, busy, timeout out.
module countdown_timer #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int MAX_SEC  = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] load_val,
    input  logic       hold,
    input  logic       cancel,
    output logic [7:0] countdown_val,
    output logic       busy,
    output logic       timeout
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] P_TC = PW'(CLK_FREQ - 1);
    localparam logic [7:0] MAX_V = 8'(MAX_SEC);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_COUNT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    lv;

    assign lv = (load_val > MAX_V) ? MAX_V : load_val;

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (lv != 8'd0) begin
                        state_d = S_COUNT;
                        cnt_d   = lv;
                        busy_d  = 1'b1;
                        pcnt_d  = '0;
                    end else begin
                        // zero load expires immediately without counting
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    pcnt_d  = '0;
                end else if (start && lv != 8'd0) begin
                    cnt_d  = lv;
                    pcnt_d = '0;
                end else if (start) begin
                    // restart with zero behaves like natural expiry
                    state_d   = S_IDLE;
                    cnt_d     = 8'd0;
                    busy_d    = 1'b0;
                    pcnt_d    = '0;
                    timeout_d = 1'b1;
                end else if (hold) begin
                    // everything frozen, partial second preserved
                end else if (pcnt_q == P_TC) begin
                    pcnt_d = '0;
                    if (cnt_q > 8'd1) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        state_d   = S_IDLE;
                        cnt_d     = 8'd0;
                        busy_d    = 1'b0;
                        timeout_d = 1'b1;
                    end
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pcnt_q    <= '0;
            cnt_q     <= 8'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign countdown_val = cnt_q;
    assign busy          = busy_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: vector table plus hand sequences for the
// countdown timer, run with CLK_FREQ=10 and MAX_SEC=15.
module tb_countdown_timer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] load_val;
    logic       hold;
    logic       cancel;
    logic [7:0] countdown_val;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] cnt;
        logic       busy;
        logic       to;
        string      name;
    } exp_t;

    typedef struct {
        logic       start;
        logic [7:0] lv;
        logic       hold;
        logic       cancel;
        logic [7:0] cnt;
        logic       busy;
        logic       to;
    } vec_t;

    exp_t exp_q[$];

    countdown_timer #(.CLK_FREQ(10), .MAX_SEC(15)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .load_val(load_val),
        .hold(hold),
        .cancel(cancel),
        .countdown_val(countdown_val),
        .busy(busy),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [7:0] c, logic b, logic t);
        total++;
        if (countdown_val !== c || busy !== b || timeout !== t) begin
            bad++;
            $display("FAIL %s: got cnt=%0d busy=%0b to=%0b want cnt=%0d busy=%0b to=%0b",
                     name, countdown_val, busy, timeout, c, b, t);
        end
    endtask

    // drive on negedge, expect after the next posedge
    task automatic step(logic s, logic [7:0] lv, logic h, logic c,
                        logic [7:0] ec, logic eb, logic et, string name);
        exp_t e;
        @(negedge clk);
        start = s; load_val = lv; hold = h; cancel = c;
        exp_q.push_back('{cnt: ec, busy: eb, to: et, name: name});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(e.name, e.cnt, e.busy, e.to);
    endtask

    vec_t vecs[$];

    initial begin
        int ec;
        rst = 1'b1; start = 1'b0; load_val = 8'd0; hold = 1'b0; cancel = 1'b0;
        #2;
        chk("reset", 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // table: idle no-ops, clamp, zero load, cancel priority, restart
        vecs.push_back('{0, 8'd0,   0, 0, 8'd0,  0, 0});
        vecs.push_back('{0, 8'd0,   1, 0, 8'd0,  0, 0});
        vecs.push_back('{0, 8'd7,   0, 1, 8'd0,  0, 0});
        vecs.push_back('{1, 8'd200, 0, 0, 8'd15, 1, 0});
        vecs.push_back('{0, 8'd0,   0, 0, 8'd15, 1, 0});
        vecs.push_back('{0, 8'd0,   0, 1, 8'd0,  0, 0});
        vecs.push_back('{1, 8'd0,   0, 0, 8'd0,  0, 1});
        vecs.push_back('{0, 8'd0,   0, 0, 8'd0,  0, 0});
        vecs.push_back('{1, 8'd5,   0, 0, 8'd5,  1, 0});
        vecs.push_back('{1, 8'd9,   0, 1, 8'd0,  0, 0});
        vecs.push_back('{0, 8'd0,   0, 0, 8'd0,  0, 0});
        vecs.push_back('{1, 8'd16,  0, 0, 8'd15, 1, 0});
        vecs.push_back('{1, 8'd15,  0, 0, 8'd15, 1, 0});
        vecs.push_back('{1, 8'd0,   0, 0, 8'd0,  0, 1});
        vecs.push_back('{0, 8'd0,   0, 0, 8'd0,  0, 0});
        vecs.push_back('{1, 8'd1,   0, 0, 8'd1,  1, 0});
        vecs.push_back('{0, 8'd0,   1, 0, 8'd1,  1, 0});
        vecs.push_back('{1, 8'd3,   1, 1, 8'd0,  0, 0});
        vecs.push_back('{0, 8'd0,   0, 0, 8'd0,  0, 0});
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].start, vecs[i].lv, vecs[i].hold, vecs[i].cancel,
                 vecs[i].cnt, vecs[i].busy, vecs[i].to, $sformatf("vec%0d", i));
        end

        // basic countdown: 3,2,1,0 at +1,+11,+21,+31
        step(1, 8'd3, 0, 0, 8'd3, 1, 0, "basic k1");
        for (int k = 2; k <= 32; k++) begin
            ec = (k <= 30) ? 3 - (k - 1) / 10 : 0;
            step(0, 8'd0, 0, 0, 8'(ec), k <= 30, k == 31, $sformatf("basic k%0d", k));
        end

        // hold for 7 cycles from +4: decrement at +18, timeout at +28
        step(1, 8'd2, 0, 0, 8'd2, 1, 0, "hold k1");
        for (int j = 1; j <= 28; j++) begin
            int k;
            k = j + 1;
            ec = (k <= 17) ? 2 : (k <= 27) ? 1 : 0;
            step(0, 8'd0, (j >= 4 && j <= 10), 0, 8'(ec), k <= 27, k == 28,
                 $sformatf("hold k%0d", k));
        end

        // restart at cnt=2, pcnt=6: next decrement 10 cycles later
        step(1, 8'd3, 0, 0, 8'd3, 1, 0, "rs k1");
        for (int j = 1; j <= 16; j++) begin
            ec = (j + 1 <= 10) ? 3 : 2;
            step(0, 8'd0, 0, 0, 8'(ec), 1, 0, $sformatf("rs k%0d", j + 1));
        end
        step(1, 8'd4, 0, 0, 8'd4, 1, 0, "rs load");
        for (int j = 1; j <= 10; j++) begin
            ec = (j < 10) ? 4 : 3;
            step(0, 8'd0, 0, 0, 8'(ec), 1, 0, $sformatf("rs after%0d", j));
        end
        step(0, 8'd0, 0, 1, 8'd0, 0, 0, "rs cancel");

        // async reset mid-second
        step(1, 8'd5, 0, 0, 8'd5, 1, 0, "ar load");
        for (int j = 1; j <= 4; j++) begin
            step(0, 8'd0, 0, 0, 8'd5, 1, 0, $sformatf("ar run%0d", j));
        end
        #2 rst = 1'b1;
        #1 chk("ar immediate", 8'd0, 1'b0, 1'b0);
        step(0, 8'd0, 0, 0, 8'd0, 0, 0, "ar held");
        rst = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            step(0, 8'd0, 0, 0, 8'd0, 0, 0, $sformatf("ar idle%0d", j));
        end

        // async reset in the expiry cycle drops the pulse
        step(1, 8'd1, 0, 0, 8'd1, 1, 0, "ax load");
        for (int j = 1; j <= 9; j++) begin
            step(0, 8'd0, 0, 0, 8'd1, 1, 0, $sformatf("ax run%0d", j));
        end
        step(0, 8'd0, 0, 0, 8'd0, 0, 1, "ax expire");
        #2 rst = 1'b1;
        #1 chk("ax immediate", 8'd0, 1'b0, 1'b0);
        step(0, 8'd0, 0, 0, 8'd0, 0, 0, "ax held");
        rst = 1'b0;
        step(0, 8'd0, 0, 0, 8'd0, 0, 0, "ax after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
